// File: rtl/nios2_mult_cell_seq_if.sv
// rtl/nios2_mult_cell_seq_if.sv - operand/result handshake bundle for the sequential multiplier cell
interface nios2_mult_cell_seq_if #(
  parameter int DATA_W = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/nios2_mult_cell_seq.sv
// rtl/nios2_mult_cell_seq.sv - limb-serial multiplier producing MUL/MULXSS/MULXSU/MULXUU results
module nios2_mult_cell_seq #(
  parameter int DATA_W = 32,
  parameter int PART_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  nios2_mult_cell_seq_if.slave bus
);
  localparam int N     = DATA_W / PART_W;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, ACCUM, CORRECT, DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   a_q, b_q, result_q;
  logic [1:0]          op_q;
  logic [ACC_W-1:0]    acc;
  logic [IW-1:0]       i_q, j_q, last_j;
  logic                accept, last_pair;
  logic [2*PART_W-1:0] pprod;
  logic [ACC_W-1:0]    term;
  logic [DATA_W-1:0]   hi, corr;

  assign accept       = (state == IDLE) && bus.in_valid && !bus.flush;
  assign bus.in_ready = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_result = result_q;

  // MUL only needs pairs that land in the low half: i + j < N
  assign last_j    = (op_q == 2'b00) ? IW'(N - 1) - i_q : IW'(N - 1);
  assign last_pair = (i_q == IW'(N - 1)) && (j_q == last_j);

  always_comb begin
    pprod = a_q[i_q*PART_W +: PART_W] * b_q[j_q*PART_W +: PART_W];
    term  = ACC_W'(pprod) << (PART_W * ({1'b0, i_q} + {1'b0, j_q}));
    hi    = acc[ACC_W-1:DATA_W];
    // Unsigned product high half, minus the terms a negative operand contributes
    case (op_q)
      2'b00:   corr = acc[DATA_W-1:0];
      2'b01:   corr = hi - (a_q[DATA_W-1] ? b_q : '0) - (b_q[DATA_W-1] ? a_q : '0);
      2'b10:   corr = hi - (a_q[DATA_W-1] ? b_q : '0);
      default: corr = hi;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCUM;
      ACCUM:   if (last_pair) state_nxt = CORRECT;
      CORRECT: state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        a_q  <= bus.in_a;
        b_q  <= bus.in_b;
        op_q <= bus.in_op;
        acc  <= '0;
        i_q  <= '0;
        j_q  <= '0;
      end else if (state == ACCUM && !bus.flush) begin
        acc <= acc + term;
        if (j_q == last_j) begin
          j_q <= '0;
          i_q <= i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
      if (state == CORRECT && !bus.flush) result_q <= corr;
    end
  end
endmodule

// File: tb/tb_nios2_mult_cell_seq.sv
// tb/tb_nios2_mult_cell_seq.sv - self-checking bench for the sequential multiplier cell
module tb_nios2_mult_cell_seq;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios2_mult_cell_seq_if #(.DATA_W(32)) b32 ();
  nios2_mult_cell_seq_if #(.DATA_W(64)) b64 ();

  nios2_mult_cell_seq #(.DATA_W(32), .PART_W(16)) u32 (.clk(clk), .reset(reset), .bus(b32));
  nios2_mult_cell_seq #(.DATA_W(64), .PART_W(16)) u64 (.clk(clk), .reset(reset), .bus(b64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full-width two's complement product, then pick the requested half
  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input int w);
    logic [127:0] ea, eb, p;
    logic [63:0]  m;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ea = {64'd0, a & m};
    eb = {64'd0, b & m};
    if ((op == 2'b01 || op == 2'b10) && a[w-1]) ea = ea - (128'd1 << w);
    if (op == 2'b01 && b[w-1]) eb = eb - (128'd1 << w);
    p = ea * eb;
    if (op == 2'b00) return p[63:0] & m;
    p = p >> w;
    return p[63:0] & m;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input int n);
    return ((op == 2'b00) ? n * (n + 1) / 2 : n * n) + 2;
  endfunction

  task automatic op32(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    int lat;
    b32.in_valid = 1'b1; b32.in_op = op; b32.in_a = a; b32.in_b = b;
    @(posedge clk); #1;
    b32.in_valid = 1'b0; b32.in_a = $urandom; b32.in_b = $urandom; b32.in_op = 2'($urandom);
    lat = 1;
    while (!b32.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(op, 2)));
    chk({tag, "_res"}, 64'(b32.out_result), 64'(exp));
    if (b32.out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_drop"}, 64'(b32.out_valid), 64'd0);
    end
  endtask

  task automatic op64(input string tag, input logic [1:0] op, input logic [63:0] a,
                      input logic [63:0] b);
    int lat;
    b64.in_valid = 1'b1; b64.in_op = op; b64.in_a = a; b64.in_b = b;
    @(posedge clk); #1;
    b64.in_valid = 1'b0; b64.in_a = {$urandom, $urandom}; b64.in_b = {$urandom, $urandom};
    lat = 1;
    while (!b64.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(op, 4)));
    chk({tag, "_res"}, b64.out_result, ref_mul(op, a, b, 64));
    @(posedge clk); #1;
    chk({tag, "_drop"}, 64'(b64.out_valid), 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb, held;
    logic [63:0] wa, wb;
    int          seen;

    reset = 1'b1;
    b32.flush = 0; b32.in_valid = 0; b32.in_op = 0; b32.in_a = 0; b32.in_b = 0; b32.out_ready = 1;
    b64.flush = 0; b64.in_valid = 0; b64.in_op = 0; b64.in_a = 0; b64.in_b = 0; b64.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_out_result", 64'(b32.out_result), 64'd0);
    chk("rst_in_ready64", 64'(b64.in_ready), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    op32("t1_mul", 2'b00, 32'h00012345, 32'h00010000, 32'h23450000);
    op32("t2_mul", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    op32("t2_xuu", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    op32("t2_xss", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    op32("t2_xsu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op32("t3_xuu", 2'b11, 32'h80000000, 32'h00000002, 32'h00000001);
    op32("t3_xss", 2'b01, 32'h80000000, 32'h00000002, 32'hFFFFFFFF);

    // Back-pressure: result held while out_ready is low
    b32.out_ready = 1'b0;
    op32("t4_xsu", 2'b10, 32'h9ABCDEF0, 32'h12345678, 32'(ref_mul(2'b10, 64'h9ABCDEF0, 64'h12345678, 32)));
    held = b32.out_result;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!b32.out_valid || b32.in_ready || b32.out_result !== held) seen++;
    end
    chk("t4_stall_stable", 64'(seen), 64'd0);
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_release_valid", 64'(b32.out_valid), 64'd0);
    chk("t4_release_ready", 64'(b32.in_ready), 64'd1);
    op32("t4_next", 2'b00, 32'h00000007, 32'h00000006, 32'h0000002A);

    // Flush during the second ACCUM cycle, in_valid kept high
    b32.in_valid = 1'b1; b32.in_op = 2'b11; b32.in_a = 32'h11111111; b32.in_b = 32'h22222222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b32.flush = 1'b1;
    @(posedge clk); #1;
    chk("t5_flush_ready", 64'(b32.in_ready), 64'd1);
    chk("t5_flush_valid", 64'(b32.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t5_flush_noaccept", 64'(b32.in_ready), 64'd1);
    b32.flush = 1'b0; b32.in_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b32.out_valid) seen++;
    end
    chk("t5_no_result", 64'(seen), 64'd0);

    // Async reset while in CORRECT (MUL: three ACCUM cycles)
    b32.in_valid = 1'b1; b32.in_op = 2'b00; b32.in_a = 32'h0000FFFF; b32.in_b = 32'h0000FFFF;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(b32.out_valid), 64'd0);
    chk("t6_rst_ready", 64'(b32.in_ready), 64'd1);
    chk("t6_rst_result", 64'(b32.out_result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b32.out_valid) seen++;
    end
    chk("t6_no_partial", 64'(seen), 64'd0);

    for (int k = 0; k < 16; k++) begin
      rop = 2'($urandom); ra = $urandom; rb = $urandom;
      if (k % 4 == 0) ra[31] = 1'b1;
      op32($sformatf("r32_%0d", k), rop, ra, rb, 32'(ref_mul(rop, 64'(ra), 64'(rb), 32)));
    end
    for (int k = 0; k < 12; k++) begin
      rop = 2'(k % 4); wa = {$urandom, $urandom}; wb = {$urandom, $urandom};
      if (k % 3 == 0) wb[63] = 1'b1;
      op64($sformatf("r64_%0d", k), rop, wa, wb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
